// File: rtl/brg_cgra_pkg.sv
// Shared types for the CGRA link balancer: forward-select mode and drain FSM states.
package brg_cgra_pkg;

   typedef enum logic {eRR = 1'b0, eStatic = 1'b1} brg_bal_mode_e;

   typedef enum logic [1:0] {eRun = 2'd0, eDrain = 2'd1, eDone = 2'd2} brg_bal_state_e;

endpackage

// File: rtl/brg_link_credit_counter.sv
// Per-link outstanding-packet counter: +1 on send, -1 on return, saturating at zero.
module brg_link_credit_counter #(
   parameter int max_p = 16,
   localparam int cw_p = $clog2(max_p + 1)
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic up_i,
   input  logic down_i,
   output logic full_o,
   output logic zero_o,
   output logic underflow_o
);

   localparam logic [cw_p-1:0] max_lp = cw_p'(max_p);
   localparam logic [cw_p-1:0] one_lp = cw_p'(1);

   logic [cw_p-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d       = cnt_q;
      underflow_o = 1'b0;
      if (up_i && !down_i) begin
         cnt_d = cnt_q + one_lp;
      end else if (down_i && !up_i) begin
         // A return with nothing outstanding is flagged and the count holds at zero.
         if (cnt_q == '0) underflow_o = 1'b1;
         else             cnt_d       = cnt_q - one_lp;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

   assign full_o = (cnt_q >= max_lp);
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/brg_cgra_link_balancer.sv
// Spreads xcel forward packets over per-row proc links with credit limits, merges the
// reverse packets back round-robin, and quiesces all rows on a drain request.
module brg_cgra_link_balancer
   import brg_cgra_pkg::*;
#(
   parameter int num_links_p       = 4,
   parameter int fwd_width_p       = 64,
   parameter int rev_width_p       = 40,
   parameter int max_out_credits_p = 16,
   localparam int lg_links_lp      = $clog2(num_links_p)
) (
   input  logic                                      clk_i,
   input  logic                                      reset_i,
   input  logic [num_links_p-1:0]                    en_mask_i,
   input  logic                                      mode_i,
   input  logic                                      xcel_fwd_v_i,
   input  logic [fwd_width_p-1:0]                    xcel_fwd_data_i,
   input  logic [lg_links_lp-1:0]                    xcel_fwd_sel_i,
   output logic                                      xcel_fwd_ready_o,
   output logic [num_links_p-1:0]                    link_fwd_v_o,
   output logic [num_links_p-1:0][fwd_width_p-1:0]   link_fwd_data_o,
   input  logic [num_links_p-1:0]                    link_fwd_ready_i,
   input  logic [num_links_p-1:0]                    link_rev_v_i,
   input  logic [num_links_p-1:0][rev_width_p-1:0]   link_rev_data_i,
   output logic [num_links_p-1:0]                    link_rev_yumi_o,
   output logic                                      xcel_rev_v_o,
   output logic [rev_width_p-1:0]                    xcel_rev_data_o,
   output logic [lg_links_lp-1:0]                    xcel_rev_link_o,
   input  logic                                      xcel_rev_yumi_i,
   input  logic                                      drain_i,
   output logic                                      drain_done_o,
   output logic                                      credit_err_o
);

   localparam logic [lg_links_lp-1:0] last_lp = lg_links_lp'(num_links_p - 1);

   // Returns {found, index} of the first requester strictly after ptr, wrapping.
   function automatic logic [lg_links_lp:0] rr_pick(input logic [num_links_p-1:0] req,
                                                    input logic [lg_links_lp-1:0] ptr);
      logic [lg_links_lp:0] pick;
      int idx;
      pick = '0;
      for (int k = num_links_p; k >= 1; k--) begin
         idx = (int'(ptr) + k) % num_links_p;
         if (req[idx[lg_links_lp-1:0]]) pick = {1'b1, idx[lg_links_lp-1:0]};
      end
      return pick;
   endfunction

   brg_bal_state_e          state_q, state_d;
   brg_bal_mode_e           mode;
   logic                    lock_q, lock_d;
   logic [lg_links_lp-1:0]  lock_sel_q, lock_sel_d, fwd_ptr_q, fwd_ptr_d;
   logic                    rev_v_q, rev_v_d;
   logic [rev_width_p-1:0]  rev_data_q, rev_data_d;
   logic [lg_links_lp-1:0]  rev_link_q, rev_link_d, rev_ptr_q, rev_ptr_d;
   logic                    credit_err_q;

   logic [num_links_p-1:0]  eligible, full, zero, underflow, up;
   logic [lg_links_lp:0]    fwd_pick, rev_pick;
   logic [lg_links_lp-1:0]  fwd_sel, rev_sel;
   logic                    fwd_ok, fwd_cond, rev_grant;

   assign mode     = brg_bal_mode_e'(mode_i);
   assign eligible = en_mask_i & ~full;
   assign fwd_pick = rr_pick(eligible, fwd_ptr_q);
   assign rev_pick = rr_pick(link_rev_v_i, rev_ptr_q);
   assign rev_sel  = rev_pick[lg_links_lp-1:0];

   always_comb begin
      // A locked packet keeps its link and completes even while draining.
      if (lock_q) begin
         fwd_sel = lock_sel_q;
         fwd_ok  = 1'b1;
      end else if (mode == eStatic) begin
         fwd_sel = xcel_fwd_sel_i;
         fwd_ok  = (state_q == eRun) && eligible[xcel_fwd_sel_i];
      end else begin
         fwd_sel = fwd_pick[lg_links_lp-1:0];
         fwd_ok  = (state_q == eRun) && fwd_pick[lg_links_lp];
      end
      fwd_cond         = !reset_i && xcel_fwd_v_i && fwd_ok;
      xcel_fwd_ready_o = fwd_cond && link_fwd_ready_i[fwd_sel];
      rev_grant        = !reset_i && (!rev_v_q || xcel_rev_yumi_i) && rev_pick[lg_links_lp];
      for (int i = 0; i < num_links_p; i++) begin
         link_fwd_v_o[i]    = fwd_cond && (fwd_sel == i[lg_links_lp-1:0]);
         link_fwd_data_o[i] = reset_i ? '0 : xcel_fwd_data_i;
         link_rev_yumi_o[i] = rev_grant && (rev_sel == i[lg_links_lp-1:0]);
      end
      up = xcel_fwd_ready_o ? link_fwd_v_o : '0;
   end

   always_comb begin
      lock_d     = lock_q;
      lock_sel_d = lock_sel_q;
      fwd_ptr_d  = fwd_ptr_q;
      if (xcel_fwd_ready_o) begin
         lock_d    = 1'b0;
         fwd_ptr_d = fwd_sel;
      end else if (fwd_cond) begin
         lock_d     = 1'b1;
         lock_sel_d = fwd_sel;
      end
      rev_v_d    = rev_v_q;
      rev_data_d = rev_data_q;
      rev_link_d = rev_link_q;
      rev_ptr_d  = rev_ptr_q;
      if (rev_grant) begin
         rev_v_d    = 1'b1;
         rev_data_d = link_rev_data_i[rev_sel];
         rev_link_d = rev_sel;
         rev_ptr_d  = rev_sel;
      end else if (xcel_rev_yumi_i) begin
         rev_v_d = 1'b0;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         eRun:    if (drain_i) state_d = eDrain;
         eDrain:  if (!drain_i) state_d = eRun;
                  else if ((&zero) && !lock_q) state_d = eDone;
         eDone:   if (!drain_i) state_d = eRun;
         default: state_d = eRun;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= eRun;
         lock_q       <= 1'b0;
         lock_sel_q   <= '0;
         fwd_ptr_q    <= last_lp;
         rev_v_q      <= 1'b0;
         rev_data_q   <= '0;
         rev_link_q   <= '0;
         rev_ptr_q    <= last_lp;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_q       <= lock_d;
         lock_sel_q   <= lock_sel_d;
         fwd_ptr_q    <= fwd_ptr_d;
         rev_v_q      <= rev_v_d;
         rev_data_q   <= rev_data_d;
         rev_link_q   <= rev_link_d;
         rev_ptr_q    <= rev_ptr_d;
         credit_err_q <= credit_err_q | (|underflow);
      end
   end

   for (genvar i = 0; i < num_links_p; i++) begin : g_cred
      brg_link_credit_counter #(.max_p(max_out_credits_p)) u_cnt (
         .clk_i       (clk_i),
         .reset_i     (reset_i),
         .up_i        (up[i]),
         .down_i      (link_rev_yumi_o[i]),
         .full_o      (full[i]),
         .zero_o      (zero[i]),
         .underflow_o (underflow[i])
      );
   end

   assign xcel_rev_v_o    = rev_v_q;
   assign xcel_rev_data_o = rev_data_q;
   assign xcel_rev_link_o = rev_link_q;
   assign drain_done_o    = (state_q == eDone);
   assign credit_err_o    = credit_err_q;

endmodule
